// File: rtl/task_out_serializer_pkg.sv
// rtl/task_out_serializer_pkg.sv - shared types for the word-to-byte task output serializer
// Purpose: FSM state enum, FIFO entry layout and byte-count helper.
// Ports: none (package).
package task_out_serializer_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // 37-bit FIFO entry: word, task boundary flags and number of bytes to emit.
  typedef struct packed {
    logic [31:0] data;
    logic        first;
    logic        last;
    logic [2:0]  nbytes;
  } entry_t;

  // Non-last words always carry a full word; a last word carries the
  // requested count only when it is a legal 1..4, otherwise a full word.
  function automatic logic [2:0] calc_nbytes(input logic last, input logic [31:0] count);
    if (last && (count >= 32'd1) && (count <= 32'd4)) begin
      return count[2:0];
    end
    return 3'(BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/task_out_serializer_if.sv
// rtl/task_out_serializer_if.sv - word input and byte output stream bundle
// Purpose: groups the word-in stream and the byte-out handshake.
// Ports: i_data/i_valid/i_first/i_last/num_valid_bytes_in_last_sample (word in),
//        o_byte/o_byte_valid/o_byte_first/o_byte_last with i_byte_ready (byte out).
interface task_out_serializer_if;

  logic [31:0] i_data;
  logic        i_valid;
  logic        i_first;
  logic        i_last;
  logic [31:0] num_valid_bytes_in_last_sample;
  logic [7:0]  o_byte;
  logic        o_byte_valid;
  logic        i_byte_ready;
  logic        o_byte_first;
  logic        o_byte_last;

  // master: word source plus UART side (drives inputs, observes outputs)
  modport master (
    output i_data, i_valid, i_first, i_last, num_valid_bytes_in_last_sample, i_byte_ready,
    input  o_byte, o_byte_valid, o_byte_first, o_byte_last
  );

  // slave: the serializer itself
  modport slave (
    input  i_data, i_valid, i_first, i_last, num_valid_bytes_in_last_sample, i_byte_ready,
    output o_byte, o_byte_valid, o_byte_first, o_byte_last
  );

endinterface

// File: rtl/task_out_fifo.sv
// rtl/task_out_fifo.sv - synchronous entry FIFO feeding the serializer
// Purpose: FIFO_DEPTH-entry buffer; push accepted when not full or when popping.
// Ports: i_clk, i_rst/i_set (sync clear), i_push/i_push_data, i_pop,
//        o_head (current head entry), o_full, o_empty.
module task_out_fifo
  import task_out_serializer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_set,
  input  logic   i_push,
  input  entry_t i_push_data,
  input  logic   i_pop,
  output entry_t o_head,
  output logic   o_full,
  output logic   o_empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  entry_t mem [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign o_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign o_empty = (count_q == '0);
  assign o_head  = mem[rd_ptr_q];

  // When full, a simultaneous pop frees the slot the push lands in.
  assign do_pop  = i_pop && !o_empty;
  assign do_push = i_push && (!o_full || do_pop);

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_set) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not cleared; only the pointers define valid contents.
  always_ff @(posedge i_clk) begin
    if (do_push && !(i_rst || i_set)) begin
      mem[wr_ptr_q] <= i_push_data;
    end
  end

endmodule

// File: rtl/task_out_serializer.sv
// rtl/task_out_serializer.sv - buffers task words and emits them LSB-first as bytes
// Purpose: word FIFO plus IDLE/SEND byte serializer with sticky overflow flag.
// Ports: i_clk, i_rst (sync, active-high), i_set (task re-arm, same clear),
//        bus (word in / byte out streams), o_overflow (sticky drop), o_busy.
module task_out_serializer
  import task_out_serializer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_set,
  task_out_serializer_if.slave        bus,
  output logic                        o_overflow,
  output logic                        o_busy
);

  entry_t push_entry;
  entry_t head;
  logic   full;
  logic   empty;
  logic   pop;
  logic   load;
  logic   xfer;

  state_e      state_q, state_d;
  logic [31:0] shift_q, shift_d;       // shift_q[7:0] is the byte on o_byte
  logic [2:0]  bytes_left_q, bytes_left_d;
  logic        entry_last_q, entry_last_d;
  logic        byte_valid_q, byte_valid_d;
  logic        byte_first_q, byte_first_d;
  logic        byte_last_q, byte_last_d;
  logic        overflow_q, overflow_d;

  assign push_entry = '{
    data:   bus.i_data,
    first:  bus.i_first,
    last:   bus.i_last,
    nbytes: calc_nbytes(bus.i_last, bus.num_valid_bytes_in_last_sample)
  };

  task_out_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_set       (i_set),
    .i_push      (bus.i_valid),
    .i_push_data (push_entry),
    .i_pop       (pop),
    .o_head      (head),
    .o_full      (full),
    .o_empty     (empty)
  );

  assign xfer = byte_valid_q && bus.i_byte_ready;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bytes_left_d = bytes_left_q;
    entry_last_d = entry_last_q;
    byte_valid_d = byte_valid_q;
    byte_first_d = byte_first_q;
    byte_last_d  = byte_last_q;
    load         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          load = 1'b1;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (bytes_left_q > 3'd1) begin
            shift_d      = {8'h00, shift_q[31:8]};
            bytes_left_d = bytes_left_q - 3'd1;
            byte_first_d = 1'b0;
            byte_last_d  = entry_last_q && (bytes_left_q == 3'd2);
          end else if (!empty) begin
            // Chain straight into the next word so there is no bubble.
            load = 1'b1;
          end else begin
            state_d      = ST_IDLE;
            shift_d      = '0;
            bytes_left_d = '0;
            entry_last_d = 1'b0;
            byte_valid_d = 1'b0;
            byte_first_d = 1'b0;
            byte_last_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      state_d      = ST_SEND;
      shift_d      = head.data;
      bytes_left_d = head.nbytes;
      entry_last_d = head.last;
      byte_valid_d = 1'b1;
      byte_first_d = head.first;
      byte_last_d  = head.last && (head.nbytes == 3'd1);
    end

    pop        = load && !(i_rst || i_set);
    overflow_d = overflow_q || (bus.i_valid && full && !pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_set) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bytes_left_q <= '0;
      entry_last_q <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_first_q <= 1'b0;
      byte_last_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bytes_left_q <= bytes_left_d;
      entry_last_q <= entry_last_d;
      byte_valid_q <= byte_valid_d;
      byte_first_q <= byte_first_d;
      byte_last_q  <= byte_last_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.o_byte       = shift_q[7:0];
  assign bus.o_byte_valid = byte_valid_q;
  assign bus.o_byte_first = byte_first_q;
  assign bus.o_byte_last  = byte_last_q;
  assign o_overflow       = overflow_q;
  assign o_busy           = !empty || (state_q != ST_IDLE);

endmodule

// File: tb/tb_task_out_serializer.sv
// tb/tb_task_out_serializer.sv - self-checking bench for task_out_serializer
module tb_task_out_serializer;

  localparam int FIFO_DEPTH = 8;

  logic clk = 1'b0;
  logic rst;
  logic set;
  logic o_overflow;
  logic o_busy;

  always #5 clk = ~clk;

  task_out_serializer_if bus();

  task_out_serializer #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_set      (set),
    .bus        (bus),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending words as a queue, the word being sent as a
  // list of byte records.
  typedef struct {
    logic [31:0] data;
    bit          first;
    bit          last;
    int          nb;
  } word_t;

  typedef struct {
    logic [7:0] b;
    bit         f;
    bit         l;
  } byte_t;

  word_t m_fifo[$];
  byte_t m_cur[$];
  bit    m_send;
  bit    m_ovf;

  function automatic int word_bytes(input bit last, input logic [31:0] count);
    if (!last) return 4;
    if (count >= 1 && count <= 4) return int'(count);
    return 4;
  endfunction

  task automatic m_load(input word_t w);
    byte_t bt;
    m_cur.delete();
    for (int i = 0; i < w.nb; i++) begin
      bt.b = w.data[8*i +: 8];
      bt.f = w.first && (i == 0);
      bt.l = w.last && (i == w.nb - 1);
      m_cur.push_back(bt);
    end
    m_send = 1'b1;
  endtask

  task automatic model_update();
    word_t w;
    if (rst || set) begin
      m_fifo.delete();
      m_cur.delete();
      m_send = 1'b0;
      m_ovf  = 1'b0;
      return;
    end
    if (!m_send) begin
      if (m_fifo.size() > 0) m_load(m_fifo.pop_front());
    end else if (bus.i_byte_ready) begin
      void'(m_cur.pop_front());
      if (m_cur.size() == 0) begin
        if (m_fifo.size() > 0) m_load(m_fifo.pop_front());
        else m_send = 1'b0;
      end
    end
    if (bus.i_valid) begin
      if (m_fifo.size() < FIFO_DEPTH) begin
        w.data  = bus.i_data;
        w.first = bus.i_first;
        w.last  = bus.i_last;
        w.nb    = word_bytes(bus.i_last, bus.num_valid_bytes_in_last_sample);
        m_fifo.push_back(w);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare();
    check("busy", 32'(o_busy), 32'(m_fifo.size() > 0 || m_send));
    check("overflow", 32'(o_overflow), 32'(m_ovf));
    check("byte_valid", 32'(bus.o_byte_valid), 32'(m_send));
    if (m_send) begin
      check("byte", 32'(bus.o_byte), 32'(m_cur[0].b));
      check("byte_first", 32'(bus.o_byte_first), 32'(m_cur[0].f));
      check("byte_last", 32'(bus.o_byte_last), 32'(m_cur[0].l));
    end else begin
      check("idle_first", 32'(bus.o_byte_first), 32'd0);
      check("idle_last", 32'(bus.o_byte_last), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic drive_idle();
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_first = 1'b0;
    bus.i_last  = 1'b0;
    bus.num_valid_bytes_in_last_sample = '0;
  endtask

  task automatic drive_word(input logic [31:0] d, input bit f, input bit l, input logic [31:0] cnt);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    bus.i_first = f;
    bus.i_last  = l;
    bus.num_valid_bytes_in_last_sample = cnt;
  endtask

  task automatic drain(input string tag);
    int c;
    bus.i_byte_ready = 1'b1;
    drive_idle();
    c = 0;
    while ((m_send || m_fifo.size() > 0) && c < 2000) begin
      step();
      c++;
    end
    check({tag, "_drained"}, 32'(c < 2000), 32'd1);
    check({tag, "_not_busy"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp40 [4];
    int         c;
    bit         marked;

    exp40[0] = 8'h11; exp40[1] = 8'h22; exp40[2] = 8'h33; exp40[3] = 8'h44;
    m_send = 1'b0;
    m_ovf  = 1'b0;
    rst = 1'b1;
    set = 1'b0;
    bus.i_byte_ready = 1'b0;
    drive_idle();
    @(negedge clk);
    step();
    step();
    check("rst_valid", 32'(bus.o_byte_valid), 32'd0);
    check("rst_byte", 32'(bus.o_byte), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_overflow", 32'(o_overflow), 32'd0);
    rst = 1'b0;

    // Single full word: bytes appear two cycles after the write.
    bus.i_byte_ready = 1'b1;
    drive_word(32'h44332211, 1'b1, 1'b1, 32'd4);
    step();
    drive_idle();
    check("w1_latency_n1", 32'(bus.o_byte_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("w1_valid", 32'(bus.o_byte_valid), 32'd1);
      check("w1_byte", 32'(bus.o_byte), 32'(exp40[i]));
      check("w1_first", 32'(bus.o_byte_first), 32'(i == 0));
      check("w1_last", 32'(bus.o_byte_last), 32'(i == 3));
    end
    step();
    check("w1_done_valid", 32'(bus.o_byte_valid), 32'd0);

    // Partial last words: count 2, 0 and 7.
    drive_word(32'hDDCCBBAA, 1'b1, 1'b1, 32'd2);
    step();
    drive_word(32'h87654321, 1'b1, 1'b1, 32'd0);
    step();
    drive_word(32'h0F1E2D3C, 1'b0, 1'b1, 32'd7);
    step();
    drain("partial");

    // Ready toggling over three words.
    drive_word(32'h03020100, 1'b1, 1'b0, 32'd0);
    step();
    drive_word(32'h07060504, 1'b0, 1'b0, 32'd0);
    step();
    drive_word(32'h0B0A0908, 1'b0, 1'b1, 32'd4);
    step();
    drive_idle();
    c = 0;
    while ((m_send || m_fifo.size() > 0) && c < 200) begin
      bus.i_byte_ready = ~bus.i_byte_ready;
      step();
      c++;
    end
    check("toggle_drained", 32'(c < 200), 32'd1);

    // Overflow: one word is held by the serializer, so DEPTH+2 writes drop one.
    bus.i_byte_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      drive_word($urandom, i == 0, i == FIFO_DEPTH + 1, 32'd4);
      step();
    end
    drive_idle();
    step();
    check("ovf_set", 32'(o_overflow), 32'd1);
    drain("ovf");
    check("ovf_sticky", 32'(o_overflow), 32'd1);

    // Re-arm while the second byte is on the bus.
    drive_word(32'hA1B2C3D4, 1'b1, 1'b1, 32'd4);
    step();
    drive_idle();
    step();
    step();
    check("set_mid_byte", 32'(bus.o_byte), 32'hC3);
    set = 1'b1;
    step();
    set = 1'b0;
    check("set_valid", 32'(bus.o_byte_valid), 32'd0);
    check("set_busy", 32'(o_busy), 32'd0);
    check("set_overflow", 32'(o_overflow), 32'd0);
    drive_word(32'h55667788, 1'b1, 1'b1, 32'd3);
    step();
    drain("after_set");

    // Full FIFO with a write landing on the same cycle as a pop.
    bus.i_byte_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      drive_word($urandom, i == 0, 1'b0, 32'd0);
      step();
    end
    drive_idle();
    check("full_count", 32'(m_fifo.size()), 32'(FIFO_DEPTH));
    check("full_no_ovf", 32'(o_overflow), 32'd0);
    marked = 1'b0;
    c = 0;
    while (!marked && c < 20) begin
      bus.i_byte_ready = 1'b1;
      if (m_cur.size() == 1) begin
        drive_word(32'hFEEDF00D, 1'b0, 1'b1, 32'd4);
        marked = 1'b1;
      end else begin
        drive_idle();
      end
      step();
      c++;
    end
    check("pop_push_marked", 32'(marked), 32'd1);
    check("pop_push_no_ovf", 32'(o_overflow), 32'd0);
    check("pop_push_tail", m_fifo[m_fifo.size()-1].data, 32'hFEEDF00D);
    drain("pop_push");

    // Randomized traffic with occasional re-arm.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(2, 0) != 0) begin
        drive_word($urandom, $urandom_range(3, 0) == 0, $urandom_range(2, 0) == 0,
                   32'($urandom_range(7, 0)));
      end else begin
        drive_idle();
      end
      bus.i_byte_ready = (i % 400 < 200) ? ($urandom_range(3, 0) != 0) : ($urandom_range(3, 0) == 0);
      set = ($urandom_range(99, 0) == 0);
      step();
    end
    set = 1'b0;
    drain("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
